spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
Slave-side model of the W25Q32-class SPI flash that the bubble emulator core reads its bubble images from. It runs on MCLK, oversamples nROMCS/ROMCLK/ROMMOSI and decodes READ (0x03) and FAST READ (0x0B). It fetches bytes through a simple synchronous memory read port and shifts them out on ROMMISO, MSB first. It is used in simulation benches and in FPGA loopback builds in place of the physical flash.

Parameters:
ADDR_WIDTH, 24, width of flash byte address and MEM_ADDR
DUMMY_BITS, 8, dummy clocks after address for FAST READ (0x0B)

Ports:
MCLK  in  1  system clock (48 MHz)
RST  in  1  asynchronous active-high reset
nROMCS  in  1  flash chip select, active low
ROMCLK  in  1  SPI clock, mode 0
ROMMOSI  in  1  serial data from master
ROMMISO  out  1  serial data to master
ROMMISO_OE  out  1  ROMMISO drive enable (1 = driven, 0 = high-Z at pad)
MEM_ADDR  out  ADDR_WIDTH  byte address to image memory
MEM_RD  out  1  one-cycle read strobe; MEM_DATA valid exactly 1 MCLK later
MEM_DATA  in  8  read data from image memory
BUSY  out  1  high while a transaction is in progress (any state except IDLE)
CMD_ERR  out  1  one-cycle pulse when an unsupported opcode is received

Behaviour:
- Reset: all outputs 0; state IDLE; shift registers and counters cleared. RST may assert at any time, mid-transaction included.
- Input synchronisation: 2-FF synchronisers on nROMCS, ROMCLK and ROMMOSI, then a third register for edge detection. Rise/fall of synced ROMCLK is an event for one MCLK cycle.
- Master constraint: ROMCLK high and low phases are each >= 3 MCLK cycles. nCS setup and hold to the first and last ROMCLK edge are >= 3 MCLK cycles.
- SPI mode 0: ROMMOSI is sampled on the ROMCLK rise event. ROMMISO updates on the ROMCLK fall event.
- nROMCS high (synced) at any time: go to IDLE, ROMMISO_OE = 0, ROMMISO = 0, bit and byte counters cleared. A partial byte is discarded.
- States:
  - IDLE: on synced nROMCS low, go to CMD with bit counter 0.
  - CMD: shift 8 rise-sampled bits in, MSB first. After the 8th bit:
    - 0x03 -> ADDR
    - 0x0B -> ADDR with the fast flag set
    - any other opcode -> IGNORE, with CMD_ERR pulsed for 1 cycle.
  - ADDR: shift ADDR_WIDTH bits in, MSB first. After the last bit:
    - fast flag set -> DUMMY
    - fast flag clear -> issue the first fetch and go to DATA.
  - DUMMY: count DUMMY_BITS rise events, ignore MOSI, then issue the first fetch and go to DATA.
  - DATA:
    - First fall event after entry: ROMMISO_OE = 1 and ROMMISO = bit 7 of the fetched byte.
    - Each later fall event shifts out the next bit.
    - After bit 0 of a byte has been driven, the next fall event loads bit 7 of the next byte.
  - IGNORE: no outputs driven; wait for nROMCS high.
- Fetch:
  - MEM_ADDR is set and MEM_RD pulsed on the cycle after the triggering rise event.
  - MEM_DATA is latched into the next-byte buffer 1 cycle after MEM_RD.
  - The next fetch, at MEM_ADDR+1, is issued on the cycle after bit 7 of the current byte is driven. This leaves >= 6 MCLK cycles before the buffer is needed.
  - The address increments modulo 2^ADDR_WIDTH: 0xFFFFFF wraps to 0x000000.
- Data continues indefinitely while nROMCS stays low. There is no byte limit.
- MOSI activity during DATA is ignored.
- BUSY = (state != IDLE), registered.
- Simultaneous nROMCS rise and a ROMCLK edge in the same cycle: nROMCS wins, and the edge is ignored.
- Power-up and after reset, no command state is remembered; each nROMCS low starts fresh in CMD.

Test Plan:
- READ 0x03, address 0x000100, 3 bytes clocked, memory holding 0xA5,0x3C,0xFF at 0x100-0x102 -> MISO returns A5 3C FF MSB-first. MEM_RD pulses at addresses 0x100, 0x101, 0x102, 0x103 (prefetch). OE is high only in DATA.
- FAST READ 0x0B, address 0x001000, 8 dummy clocks, memory 0x5A at 0x1000 -> first data bit appears on the fall after the 8th dummy rise. The byte reads 0x5A.
- Wrap: READ at 0xFFFFFF for 2 bytes -> MEM_ADDR sequence 0xFFFFFF, 0x000000. Second byte equals mem[0].
- Unsupported opcode 0x9F -> CMD_ERR high exactly 1 cycle after the 8th bit. OE stays 0 for the rest of the transaction. The next transaction with 0x03 works normally.
- nROMCS deasserted after 4 bits of a data byte, then a new READ at 0x000200 -> OE drops within 3 MCLK of the CS rise and BUSY goes low. The new read returns mem[0x200] from bit 7.
- RST asserted mid-ADDR -> all outputs 0 asynchronously. After RST release and a fresh 0x03 transaction, the correct data is returned.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI flash responder: a slave-side stand-in for a W25Q32-class serial flash.
// It oversamples the SPI pins on MCLK and decodes READ (0x03) and FAST READ (0x0B).
// Image bytes come from a synchronous memory port and are shifted out MSB first.
module spi_flash_responder #(
    parameter int ADDR_WIDTH = 24,
    parameter int DUMMY_BITS = 8
) (
    input  logic                  MCLK,
    input  logic                  RST,
    input  logic                  nROMCS,
    input  logic                  ROMCLK,
    input  logic                  ROMMOSI,
    output logic                  ROMMISO,
    output logic                  ROMMISO_OE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_RD,
    input  logic [7:0]            MEM_DATA,
    output logic                  BUSY,
    output logic                  CMD_ERR
);

    // The shared bit counter must reach the longest of the opcode, address and dummy fields.
    localparam int MAX_BITS = (ADDR_WIDTH > DUMMY_BITS) ? ADDR_WIDTH : DUMMY_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    // Synchroniser stages. Chip select resets to the deasserted level,
    // so the block does not see a false select when reset is released.
    logic cs_s1_q, cs_s2_q;
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic mosi_s1_q, mosi_s2_q;
    logic rise_s, fall_s;

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [ADDR_WIDTH-2:0]  shift_q;
    logic                   fast_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic                   mem_rd_q;
    logic                   rd_dly_q;
    logic                   fetch_pend_q;
    logic [7:0]             buf_q;
    logic [7:0]             cur_q;
    logic [2:0]             out_cnt_q;
    logic                   first_q;
    logic                   miso_q;
    logic                   oe_q;
    logic                   busy_q;
    logic                   cmd_err_q;

    // Bring the asynchronous SPI pins into the MCLK domain; the third clock stage is for edge detection.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            clk_s3_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= nROMCS;
            cs_s2_q   <= cs_s1_q;
            clk_s1_q  <= ROMCLK;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            mosi_s1_q <= ROMMOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign rise_s = clk_s2_q & ~clk_s3_q;
    assign fall_s = ~clk_s2_q & clk_s3_q;

    // Protocol FSM. It decodes the opcode, address and dummy fields, paces memory fetches and shifts out MISO.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= {CNT_W{1'b0}};
            shift_q      <= {(ADDR_WIDTH-1){1'b0}};
            fast_q       <= 1'b0;
            mem_addr_q   <= {ADDR_WIDTH{1'b0}};
            mem_rd_q     <= 1'b0;
            rd_dly_q     <= 1'b0;
            fetch_pend_q <= 1'b0;
            buf_q        <= 8'h00;
            cur_q        <= 8'h00;
            out_cnt_q    <= 3'd0;
            first_q      <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            mem_rd_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            rd_dly_q  <= mem_rd_q;
            // The memory returns data the cycle after the strobe, so capture it one cycle later.
            if (rd_dly_q) begin
                buf_q <= MEM_DATA;
            end

            if (cs_s2_q) begin
                // A deselect overrides everything, including a clock edge in the same cycle.
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                oe_q         <= 1'b0;
                miso_q       <= 1'b0;
                bit_cnt_q    <= {CNT_W{1'b0}};
                out_cnt_q    <= 3'd0;
                fetch_pend_q <= 1'b0;
                first_q      <= 1'b0;
                fast_q       <= 1'b0;
            end else begin
                // Prefetch the following byte once the current byte has been loaded for output.
                if (fetch_pend_q) begin
                    mem_rd_q     <= 1'b1;
                    mem_addr_q   <= mem_addr_q + ADDR_WIDTH'(1);
                    fetch_pend_q <= 1'b0;
                end

                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_CMD;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= {CNT_W{1'b0}};
                    end
                    ST_CMD: begin
                        if (rise_s) begin
                            shift_q <= {shift_q[ADDR_WIDTH-3:0], mosi_s2_q};
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= {CNT_W{1'b0}};
                                case ({shift_q[6:0], mosi_s2_q})
                                    8'h03: begin
                                        state_q <= ST_ADDR;
                                        fast_q  <= 1'b0;
                                    end
                                    8'h0B: begin
                                        state_q <= ST_ADDR;
                                        fast_q  <= 1'b1;
                                    end
                                    default: begin
                                        state_q   <= ST_IGNORE;
                                        cmd_err_q <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_s) begin
                            shift_q <= {shift_q[ADDR_WIDTH-3:0], mosi_s2_q};
                            if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                                bit_cnt_q  <= {CNT_W{1'b0}};
                                mem_addr_q <= {shift_q, mosi_s2_q};
                                if (fast_q) begin
                                    state_q <= ST_DUMMY;
                                end else begin
                                    state_q  <= ST_DATA;
                                    mem_rd_q <= 1'b1;
                                    first_q  <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DUMMY: begin
                        // The address is already on MEM_ADDR; the strobe waits for the last dummy clock.
                        if (rise_s) begin
                            if (bit_cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
                                bit_cnt_q <= {CNT_W{1'b0}};
                                state_q   <= ST_DATA;
                                mem_rd_q  <= 1'b1;
                                first_q   <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (fall_s) begin
                            if (first_q || (out_cnt_q == 3'd0)) begin
                                // Start a new byte from the prefetch buffer and request the next one.
                                oe_q         <= 1'b1;
                                miso_q       <= buf_q[7];
                                cur_q        <= {buf_q[6:0], 1'b0};
                                out_cnt_q    <= 3'd7;
                                first_q      <= 1'b0;
                                fetch_pend_q <= 1'b1;
                            end else begin
                                miso_q    <= cur_q[7];
                                cur_q     <= {cur_q[6:0], 1'b0};
                                out_cnt_q <= out_cnt_q - 3'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        state_q <= ST_IGNORE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ROMMISO    = miso_q;
    assign ROMMISO_OE = oe_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_RD     = mem_rd_q;
    assign BUSY       = busy_q;
    assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: expected fetch addresses and bytes are queued
// by the stimulus, and independent monitors pop and compare them as the DUT produces them.
module tb_spi_flash_responder;

    logic        mclk = 1'b0;
    logic        rst  = 1'b0;
    logic        ncs  = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, oe, mem_rd, busy, cmd_err;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    bit oe_seen = 1'b0;

    logic [23:0] exp_addr[$];
    logic [7:0]  exp_byte[$];
    bit   [7:0]  mem[bit [23:0]];

    spi_flash_responder #(.ADDR_WIDTH(24), .DUMMY_BITS(8)) dut (
        .MCLK(mclk), .RST(rst), .nROMCS(ncs), .ROMCLK(sclk), .ROMMOSI(mosi),
        .ROMMISO(miso), .ROMMISO_OE(oe), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd),
        .MEM_DATA(mem_data), .BUSY(busy), .CMD_ERR(cmd_err)
    );

    always #10 mclk = ~mclk;

    // Synchronous image memory: data is valid the cycle after the strobe.
    always @(posedge mclk) begin
        if (mem_rd) mem_data <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every memory strobe must match the next expected fetch address.
    always @(negedge mclk) begin
        if (oe === 1'b1) oe_seen = 1'b1;
        if (cmd_err === 1'b1) err_cnt++;
        if (mem_rd === 1'b1) begin
            if (exp_addr.size() == 0) check("unexpected_mem_rd", 32'(mem_addr), 32'hFFFFFFFF);
            else check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        end
    end

    // Monitor: the master samples MISO on each rising SCLK while MISO is driven.
    logic [7:0] rx = 8'h00;
    int rx_n = 0;
    always @(posedge sclk or posedge ncs) begin
        if (ncs) begin
            rx_n = 0;
        end else if (oe === 1'b1) begin
            rx = {rx[6:0], miso};
            rx_n++;
            if (rx_n == 8) begin
                rx_n = 0;
                if (exp_byte.size() == 0) check("unexpected_byte", 32'(rx), 32'hFFFFFFFF);
                else check("miso_byte", 32'(rx), 32'(exp_byte.pop_front()));
            end
        end
    end

    task automatic wait_mclk(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic cs_low;
        ncs = 1'b0;
        wait_mclk(6);
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0;
        mosi = b;
        wait_mclk(6);
        sclk = 1'b1;
        wait_mclk(6);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Deselect with SCLK still high so that no trailing falling edge is seen.
    task automatic cs_high;
        ncs = 1'b1;
        wait_mclk(6);
        sclk = 1'b0;
        wait_mclk(6);
    endtask

    task automatic read_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes, input bit fast);
        oe_seen = 1'b0;
        cs_low();
        send_byte(cmd);
        send_byte(addr[23:16]);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (fast) send_byte(8'h00);
        check("oe_before_data", 32'(oe_seen), 32'd0);
        for (int i = 0; i < nbytes * 8; i++) send_bit(1'b0);
        cs_high();
        check("oe_after_txn", 32'(oe), 32'd0);
        check("busy_after_txn", 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[24'h000100] = 8'hA5; mem[24'h000101] = 8'h3C; mem[24'h000102] = 8'hFF;
        mem[24'h000103] = 8'h77; mem[24'h001000] = 8'h5A; mem[24'hFFFFFF] = 8'h11;
        mem[24'h000000] = 8'h22; mem[24'h000300] = 8'h96; mem[24'h000200] = 8'hC3;

        // Reset state
        #1 rst = 1'b1;
        wait_mclk(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        wait_mclk(4);
        check("idle_busy", 32'(busy), 32'd0);

        // READ of three bytes, with a prefetch of the fourth address
        exp_addr.push_back(24'h000100); exp_addr.push_back(24'h000101);
        exp_addr.push_back(24'h000102); exp_addr.push_back(24'h000103);
        exp_byte.push_back(8'hA5); exp_byte.push_back(8'h3C); exp_byte.push_back(8'hFF);
        read_txn(8'h03, 24'h000100, 3, 1'b0);

        // FAST READ with eight dummy clocks
        exp_addr.push_back(24'h001000); exp_addr.push_back(24'h001001);
        exp_byte.push_back(8'h5A);
        read_txn(8'h0B, 24'h001000, 1, 1'b1);

        // Address wrap from the top of the address space
        exp_addr.push_back(24'hFFFFFF); exp_addr.push_back(24'h000000); exp_addr.push_back(24'h000001);
        exp_byte.push_back(8'h11); exp_byte.push_back(8'h22);
        read_txn(8'h03, 24'hFFFFFF, 2, 1'b0);

        // Unsupported opcode
        err_cnt = 0;
        oe_seen = 1'b0;
        cs_low();
        send_byte(8'h9F);
        check("cmd_err_pulse", 32'(err_cnt), 32'd1);
        send_byte(8'h00);
        send_byte(8'hFF);
        cs_high();
        check("cmd_err_single", 32'(err_cnt), 32'd1);
        check("ignore_oe", 32'(oe_seen), 32'd0);
        exp_addr.push_back(24'h000102); exp_addr.push_back(24'h000103);
        exp_byte.push_back(8'hFF);
        read_txn(8'h03, 24'h000102, 1, 1'b0);

        // Abort partway through a data byte, then start a new read
        exp_addr.push_back(24'h000300); exp_addr.push_back(24'h000301);
        cs_low();
        send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        ncs = 1'b1;
        wait_mclk(3);
        check("abort_oe_drop", 32'(oe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        wait_mclk(3);
        sclk = 1'b0;
        wait_mclk(6);
        exp_addr.push_back(24'h000200); exp_addr.push_back(24'h000201);
        exp_byte.push_back(8'hC3);
        read_txn(8'h03, 24'h000200, 1, 1'b0);

        // Reset while the address field is being received
        cs_low();
        send_byte(8'h03);
        send_byte(8'h00);
        rst = 1'b1;
        #1;
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_oe", 32'(oe), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_err", 32'(cmd_err), 32'd0);
        wait_mclk(2);
        ncs = 1'b1;
        sclk = 1'b0;
        wait_mclk(4);
        rst = 1'b0;
        wait_mclk(4);
        exp_addr.push_back(24'h000100); exp_addr.push_back(24'h000101);
        exp_byte.push_back(8'hA5);
        read_txn(8'h03, 24'h000100, 1, 1'b0);

        wait_mclk(10);
        check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        check("byte_queue_empty", 32'(exp_byte.size()), 32'd0);
        check("cmd_err_total", 32'(err_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
